hazard_stall_sequencer: RTL

// - Central sequencer for all pipeline stall and flush requests. It replaces the
//   per-cycle combinational hazard decision with a registered FSM.
// - Arbitrates between mispredict flush, memory wait, multi-cycle MDU busy,

---
 rtl/hazard_stall_sequencer_pkg.sv | 60 ++++++
 rtl/hazard_stall_sequencer_if.sv | 44 ++++
 rtl/hazard_stall_sequencer_sat_counter.sv | 17 +
 rtl/hazard_stall_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/hazard_stall_sequencer_pkg.sv
// Shared types and constants for the hazard stall sequencer: opcodes, state
// encoding, the per-cycle pipeline control word and small decode helpers.
package hazard_stall_sequencer_pkg;

  typedef logic [6:0] opcode_t;
  typedef logic [4:0] reg_t;

  localparam opcode_t OPC_JR  = 7'b1100111;
  localparam opcode_t OPC_BEQ = 7'b1100011;
  localparam opcode_t OPC_BNE = 7'b1100001;

  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_JR  = 2'd1;
  localparam logic [1:0] ST_MDU = 2'd2;
  localparam logic [1:0] ST_MEM = 2'd3;

  typedef enum logic [1:0] {
    S_RUN = ST_RUN,
    S_JR  = ST_JR,
    S_MDU = ST_MDU,
    S_MEM = ST_MEM
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic ex_mem_write;
    logic mem_wb_write;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam ctrl_t CTRL_MDU    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_LU     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam ctrl_t CTRL_JR     = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  function automatic logic is_jr(input opcode_t opc);
    return opc == OPC_JR;
  endfunction

  function automatic logic is_branch(input opcode_t opc);
    return (opc == OPC_BEQ) || (opc == OPC_BNE);
  endfunction

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  function automatic logic load_use_hazard(input logic memread, input reg_t rd,
                                           input reg_t rs1, input reg_t rs2);
    return memread && (rd != 5'd0) && ((rs1 == rd) || (rs2 == rd));
  endfunction

  function automatic logic any_flush(input ctrl_t c);
    return c.if_id_flush | c.id_ex_flush | c.ex_mem_flush;
  endfunction

endpackage

// File: rtl/hazard_stall_sequencer_if.sv
// Hazard request / pipeline control bundle between the pipeline and the sequencer.
interface hazard_stall_sequencer_if
  import hazard_stall_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             Wrong_prediction;
  opcode_t          if_id_opcode;
  reg_t             if_id_rs1;
  reg_t             if_id_rs2;
  logic             EX_memread;
  reg_t             id_ex_rd;
  logic             mem_req;
  logic             mem_ready;
  logic             mdu_start;
  logic             mdu_done;
  logic             PC_Write;
  logic             if_id_Write;
  logic             if_id_flush;
  logic             id_ex_Write;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             ex_mem_Write;
  logic             mem_wb_Write;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_cycles;
  logic             mem_timeout;

  modport master (
    output Wrong_prediction, if_id_opcode, if_id_rs1, if_id_rs2, EX_memread,
           id_ex_rd, mem_req, mem_ready, mdu_start, mdu_done,
    input  PC_Write, if_id_Write, if_id_flush, id_ex_Write, id_ex_flush,
           ex_mem_flush, ex_mem_Write, mem_wb_Write, stall_cycles,
           flush_cycles, mem_timeout
  );

  modport slave (
    input  Wrong_prediction, if_id_opcode, if_id_rs1, if_id_rs2, EX_memread,
           id_ex_rd, mem_req, mem_ready, mdu_start, mdu_done,
    output PC_Write, if_id_Write, if_id_flush, id_ex_Write, id_ex_flush,
           ex_mem_flush, ex_mem_Write, mem_wb_Write, stall_cycles,
           flush_cycles, mem_timeout
  );
endinterface

// File: rtl/hazard_stall_sequencer_sat_counter.sv
// Saturating up-counter used for the stall/flush profiling counts.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end
endmodule

// File: rtl/hazard_stall_sequencer.sv
// Registered stall/flush sequencer: arbitrates memory wait, mispredict, MDU,
// load-use and jr hazards and drives the pipeline register enables and flushes.
module hazard_stall_sequencer
  import hazard_stall_sequencer_pkg::*;
#(
  parameter int JR_BUBBLES  = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  hazard_stall_sequencer_if.slave bus
);
  localparam int              MEM_CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [MEM_CNT_W-1:0] MEM_LAST = MEM_CNT_W'(MEM_TIMEOUT);
  localparam logic [2:0]      JR_LOAD   = 3'(JR_BUBBLES - 1);

  state_t               state, state_nxt;
  logic [2:0]           jr_cnt, jr_cnt_nxt;
  logic [MEM_CNT_W-1:0] mem_cnt, mem_cnt_nxt;
  logic                 pend_flush, pend_nxt;
  logic                 timeout_flag, timeout_nxt;
  ctrl_t                ctrl;
  logic                 mem_stall;
  logic                 load_use;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     flush_cnt;

  assign mem_stall = bus.mem_req & ~bus.mem_ready;
  assign load_use  = load_use_hazard(bus.EX_memread, bus.id_ex_rd,
                                     bus.if_id_rs1, bus.if_id_rs2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_RUN;
      jr_cnt       <= '0;
      mem_cnt      <= '0;
      pend_flush   <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_nxt;
      jr_cnt       <= jr_cnt_nxt;
      mem_cnt      <= mem_cnt_nxt;
      pend_flush   <= pend_nxt;
      timeout_flag <= timeout_nxt;
    end
  end

  always_comb begin
    ctrl        = CTRL_RUN;
    state_nxt   = state;
    jr_cnt_nxt  = jr_cnt;
    mem_cnt_nxt = mem_cnt;
    pend_nxt    = pend_flush;
    timeout_nxt = timeout_flag;
    unique case (state)
      S_RUN, S_JR: begin
        if (mem_stall) begin
          ctrl        = CTRL_FREEZE;
          state_nxt   = S_MEM;
          mem_cnt_nxt = MEM_CNT_W'(1);
          pend_nxt    = pend_flush | bus.Wrong_prediction;
        end else if (bus.Wrong_prediction || pend_flush) begin
          ctrl      = CTRL_FLUSH;
          pend_nxt  = 1'b0;
          state_nxt = S_RUN;
        end else if (state == S_JR) begin
          ctrl       = CTRL_JR;
          jr_cnt_nxt = jr_cnt - 3'd1;
          if (jr_cnt == 3'd1) state_nxt = S_RUN;
        end else if (bus.mdu_start) begin
          ctrl = CTRL_MDU;
          if (!bus.mdu_done) state_nxt = S_MDU;
        end else if (load_use) begin
          ctrl = CTRL_LU;
        end else if (is_jr(bus.if_id_opcode)) begin
          ctrl       = CTRL_JR;
          jr_cnt_nxt = JR_LOAD;
          if (JR_LOAD != 3'd0) state_nxt = S_JR;
        end
      end
      // The exit cycle of a wait state is the first cycle the pipeline moves
      // again, so a mispredict held back during the wait is applied there.
      S_MDU: begin
        if (bus.mdu_done) begin
          ctrl      = (pend_flush || bus.Wrong_prediction) ? CTRL_FLUSH : CTRL_RUN;
          pend_nxt  = 1'b0;
          state_nxt = S_RUN;
        end else begin
          ctrl     = CTRL_MDU;
          pend_nxt = pend_flush | bus.Wrong_prediction;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          ctrl      = (pend_flush || bus.Wrong_prediction) ? CTRL_FLUSH : CTRL_RUN;
          pend_nxt  = 1'b0;
          state_nxt = S_RUN;
        end else begin
          ctrl        = CTRL_FREEZE;
          pend_nxt    = pend_flush | bus.Wrong_prediction;
          mem_cnt_nxt = mem_cnt + MEM_CNT_W'(1);
          if (mem_cnt == MEM_LAST) begin
            state_nxt   = S_RUN;
            timeout_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (~rst),
    .inc   (~ctrl.pc_write),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (~rst),
    .inc   (any_flush(ctrl)),
    .count (flush_cnt)
  );

  assign bus.PC_Write     = ctrl.pc_write;
  assign bus.if_id_Write  = ctrl.if_id_write;
  assign bus.if_id_flush  = ctrl.if_id_flush;
  assign bus.id_ex_Write  = ctrl.id_ex_write;
  assign bus.id_ex_flush  = ctrl.id_ex_flush;
  assign bus.ex_mem_flush = ctrl.ex_mem_flush;
  assign bus.ex_mem_Write = ctrl.ex_mem_write;
  assign bus.mem_wb_Write = ctrl.mem_wb_write;
  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_cycles = flush_cnt;
  assign bus.mem_timeout  = timeout_flag;

endmodule
